// File: rtl/block_word_emitter.sv
// block_word_emitter
//   Turns word commands into a serial stream of 8-bit ASCII characters.
//   Each word ends with a single space (0x20). The block also tracks the
//   begin/end nesting depth of the words it has sent.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   reset      : asynchronous, active-high; clears all state
//   cmd_valid  : a command is offered
//   cmd[1:0]   : 00 "begin", 01 "end", 10 "beginx", 11 "en"
//   upper      : 1 = upper-case letters; sampled together with cmd
//   cmd_ready  : high when a command can be accepted (IDLE only)
//   out_valid  : the character on out is valid
//   out_ready  : downstream takes the character
//   out[7:0]   : ASCII character (8'h00 when not valid)
//   depth      : completed BEGINs minus completed matched ENDs (saturating)
//   mismatch   : sticky; an END completed while depth was 0
//   ovf        : sticky; a BEGIN completed while depth was at maximum
//   balanced   : (depth == 0) && !mismatch
module block_word_emitter #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic               upper,
  output logic               cmd_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out,
  output logic [DEPTH_W-1:0] depth,
  output logic               mismatch,
  output logic               ovf,
  output logic               balanced
);

  localparam logic [1:0] CMD_BEGIN  = 2'b00;
  localparam logic [1:0] CMD_END    = 2'b01;
  localparam logic [1:0] CMD_NEAR_B = 2'b10;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = '0;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};

  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         cmd_q, cmd_d;
  logic               upper_q, upper_d;
  logic [2:0]         idx_q, idx_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               mismatch_q, mismatch_d;
  logic               ovf_q, ovf_d;

  // Lower-case character at position i of the word selected by c.
  function automatic logic [7:0] lower_char(input logic [1:0] c,
                                            input logic [2:0] i);
    logic [7:0] ch;
    ch = CH_SPACE;
    case (c)
      CMD_BEGIN, CMD_NEAR_B: begin
        case (i)
          3'd0:    ch = 8'h62;                              // b
          3'd1:    ch = 8'h65;                              // e
          3'd2:    ch = 8'h67;                              // g
          3'd3:    ch = 8'h69;                              // i
          3'd4:    ch = 8'h6E;                              // n
          3'd5:    ch = (c == CMD_NEAR_B) ? 8'h78 : CH_SPACE; // x / space
          default: ch = CH_SPACE;
        endcase
      end
      CMD_END: begin
        case (i)
          3'd0:    ch = 8'h65;                              // e
          3'd1:    ch = 8'h6E;                              // n
          3'd2:    ch = 8'h64;                              // d
          default: ch = CH_SPACE;
        endcase
      end
      default: begin
        case (i)
          3'd0:    ch = 8'h65;                              // e
          3'd1:    ch = 8'h6E;                              // n
          default: ch = CH_SPACE;
        endcase
      end
    endcase
    return ch;
  endfunction

  // Index of the terminating space for each word.
  function automatic logic [2:0] last_idx(input logic [1:0] c);
    case (c)
      CMD_BEGIN:  return 3'd5;
      CMD_END:    return 3'd3;
      CMD_NEAR_B: return 3'd6;
      default:    return 3'd2;
    endcase
  endfunction

  // Upper-case is a fixed 0x20 offset; the space passes through untouched.
  function automatic logic [7:0] apply_case(input logic [7:0] ch,
                                            input logic up);
    if (up && (ch != CH_SPACE)) return ch - 8'h20;
    return ch;
  endfunction

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    upper_d    = upper_q;
    idx_d      = idx_q;
    depth_d    = depth_q;
    mismatch_d = mismatch_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = EMIT;
          cmd_d   = cmd;
          upper_d = upper;
          idx_d   = 3'd0;
        end
      end
      default: begin
        if (out_ready) begin
          if (idx_q == last_idx(cmd_q)) begin
            // Word complete: update nesting bookkeeping, then idle one cycle.
            state_d = IDLE;
            if (cmd_q == CMD_BEGIN) begin
              if (depth_q != DEPTH_MAX) depth_d = depth_q + DEPTH_ONE;
              else                      ovf_d   = 1'b1;
            end else if (cmd_q == CMD_END) begin
              if (depth_q != DEPTH_ZERO) depth_d    = depth_q - DEPTH_ONE;
              else                       mismatch_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= 2'b00;
      upper_q    <= 1'b0;
      idx_q      <= 3'd0;
      depth_q    <= '0;
      mismatch_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      upper_q    <= upper_d;
      idx_q      <= idx_d;
      depth_q    <= depth_d;
      mismatch_q <= mismatch_d;
      ovf_q      <= ovf_d;
    end
  end

  // Outputs are decoded from registered state only, so they hold steady
  // under backpressure and drop immediately on an asynchronous reset.
  assign cmd_ready = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out       = (state_q == EMIT) ?
                     apply_case(lower_char(cmd_q, idx_q), upper_q) : 8'h00;
  assign depth     = depth_q;
  assign mismatch  = mismatch_q;
  assign ovf       = ovf_q;
  assign balanced  = (depth_q == DEPTH_ZERO) && !mismatch_q;

endmodule

// File: tb/tb_block_word_emitter.sv
module tb_block_word_emitter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       upper = 1'b0;
  logic       out_ready = 1'b1;

  logic       cmd_ready, out_valid, mismatch, ovf, balanced;
  logic [7:0] out;
  logic [7:0] depth;

  logic       cmd_ready2, out_valid2, mismatch2, ovf2, balanced2;
  logic [7:0] out2;
  logic [1:0] depth2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  block_word_emitter #(.DEPTH_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .upper(upper),
    .cmd_ready(cmd_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .depth(depth), .mismatch(mismatch), .ovf(ovf),
    .balanced(balanced)
  );

  block_word_emitter #(.DEPTH_W(2)) dut_small (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .upper(upper),
    .cmd_ready(cmd_ready2), .out_valid(out_valid2), .out_ready(out_ready),
    .out(out2), .depth(depth2), .mismatch(mismatch2), .ovf(ovf2),
    .balanced(balanced2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; leaves the bench at a negedge.
  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 8'h00);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_depth", depth, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_ovf", ovf, 0);
    check("rst_balanced", balanced, 1);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic accept(input logic [1:0] c, input logic u);
    cmd_valid = 1'b1;
    cmd = c;
    upper = u;
    check("acc_cmd_ready", cmd_ready, 1);
    check("acc_out_valid", out_valid, 0);
    @(negedge clk);
    // Scramble the inputs to confirm the command was latched.
    cmd_valid = 1'b0;
    cmd = ~c;
    upper = ~u;
  endtask

  task automatic expect_char(input int i, input logic [7:0] ch);
    check($sformatf("char%0d_valid", i), out_valid, 1);
    check($sformatf("char%0d_cmd_ready", i), cmd_ready, 0);
    check($sformatf("char%0d", i), out, ch);
    @(negedge clk);
  endtask

  // Sends a whole word, optionally stalling stall_n cycles at index stall_at,
  // then checks the single idle cycle that follows.
  task automatic emit(input logic [1:0] c, input logic u, input string exp,
                      input int stall_at, input int stall_n);
    accept(c, u);
    for (int i = 0; i < exp.len(); i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          check("stall_valid", out_valid, 1);
          check("stall_out", out, exp[i]);
          cmd_valid = 1'b1;
          cmd = 2'b01;
          @(negedge clk);
        end
        cmd_valid = 1'b0;
        out_ready = 1'b1;
      end
      expect_char(i, exp[i]);
    end
    check("idle_out_valid", out_valid, 0);
    check("idle_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    @(negedge clk);

    // Lower-case BEGIN: 62 65 67 69 6E 20.
    do_reset();
    emit(2'b00, 1'b0, "begin ", -1, 0);
    check("t1_depth", depth, 1);
    check("t1_balanced", balanced, 0);

    // Upper-case BEGIN then END.
    do_reset();
    emit(2'b00, 1'b1, "BEGIN ", -1, 0);
    emit(2'b01, 1'b1, "END ", -1, 0);
    check("t2_depth", depth, 0);
    check("t2_balanced", balanced, 1);
    check("t2_mismatch", mismatch, 0);

    // END with nothing open sets the sticky mismatch.
    do_reset();
    emit(2'b01, 1'b0, "end ", -1, 0);
    check("t3_mismatch", mismatch, 1);
    check("t3_depth", depth, 0);
    check("t3_balanced", balanced, 0);
    emit(2'b00, 1'b0, "begin ", -1, 0);
    emit(2'b01, 1'b0, "end ", -1, 0);
    check("t3_mismatch_sticky", mismatch, 1);
    check("t3_balanced_after", balanced, 0);
    check("t3_depth_after", depth, 0);

    // Near-miss words do not touch depth.
    do_reset();
    emit(2'b10, 1'b0, "beginx ", -1, 0);
    emit(2'b11, 1'b0, "en ", -1, 0);
    check("t4_depth", depth, 0);
    check("t4_balanced", balanced, 1);
    emit(2'b10, 1'b1, "BEGINX ", -1, 0);
    emit(2'b11, 1'b1, "EN ", -1, 0);
    check("t4_depth_upper", depth, 0);

    // Backpressure at idx 2 with a command pulsed during EMIT.
    do_reset();
    emit(2'b00, 1'b0, "begin ", 2, 3);
    check("t5_depth", depth, 1);
    check("t5_mismatch", mismatch, 0);

    // Asynchronous reset in the middle of a BEGIN.
    accept(2'b00, 1'b0);
    expect_char(0, 8'h62);
    expect_char(1, 8'h65);
    expect_char(2, 8'h67);
    check("t6_idx3", out, 8'h69);
    check("t6_depth_pre", depth, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_depth", depth, 0);
    check("t6_async_ready", cmd_ready, 1);
    check("t6_async_out", out, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_still_idle", out_valid, 0);
    emit(2'b01, 1'b0, "end ", -1, 0);
    check("t6_mismatch", mismatch, 1);
    check("t6_depth", depth, 0);

    // Depth saturation on the 2-bit instance.
    do_reset();
    for (int k = 0; k < 4; k++) emit(2'b00, 1'b0, "begin ", -1, 0);
    check("t7_small_depth", depth2, 3);
    check("t7_small_ovf", ovf2, 1);
    check("t7_small_mismatch", mismatch2, 0);
    check("t7_small_balanced", balanced2, 0);
    check("t7_small_ready", cmd_ready2, 1);
    check("t7_small_valid", out_valid2, 0);
    check("t7_small_out", out2, 8'h00);
    check("t7_wide_depth", depth, 4);
    check("t7_wide_ovf", ovf, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
